cluster_count_scheduler: RTL and testbench

CLUSTER_COUNT_SCHEDULER -- requirements
Module: cluster_count_scheduler

---
 rtl/cluster_count_scheduler_pkg.sv | 17 +
 rtl/cluster_count_scheduler_if.sv | 33 +++
 rtl/cluster_count_scheduler_bx_phase_gen.sv | 28 ++
 rtl/cluster_count_scheduler.sv | 96 +++++++++
 tb/tb_cluster_count_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cluster_count_scheduler_pkg.sv
// Shared types and constants for the cluster count scheduler.
package cluster_count_scheduler_pkg;
    localparam int CNT_W            = 11;
    localparam int SLOT_W           = 4;
    localparam int MAX_CLUSTERS_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_t;

    // Number of readout slots for a raw count: the count, capped at max_c.
    function automatic logic [SLOT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt,
                                                    input logic [SLOT_W-1:0] max_c);
        return (cnt > CNT_W'(max_c)) ? max_c : cnt[SLOT_W-1:0];
    endfunction
endpackage

// File: rtl/cluster_count_scheduler_if.sv
// Handshake bundle between the cluster counter pipeline, the scheduler and the readout.
interface cluster_count_scheduler_if
    import cluster_count_scheduler_pkg::*;
#(
    parameter int OVF_W = 16
);
    logic              bx0_i;
    logic [CNT_W-1:0]  cnt_i;
    logic              slot_ack_i;
    logic              clr_i;
    logic [1:0]        phase_o;
    logic              sample_o;
    logic              cnt_valid_o;
    logic [CNT_W-1:0]  cnt_o;
    logic              overflow_o;
    logic              slot_req_o;
    logic [SLOT_W-1:0] slot_idx_o;
    logic              truncated_o;
    logic [OVF_W-1:0]  ovf_cnt_o;
    logic              sync_err_o;

    modport master (
        output bx0_i, cnt_i, slot_ack_i, clr_i,
        input  phase_o, sample_o, cnt_valid_o, cnt_o, overflow_o, slot_req_o,
               slot_idx_o, truncated_o, ovf_cnt_o, sync_err_o
    );

    modport slave (
        input  bx0_i, cnt_i, slot_ack_i, clr_i,
        output phase_o, sample_o, cnt_valid_o, cnt_o, overflow_o, slot_req_o,
               slot_idx_o, truncated_o, ovf_cnt_o, sync_err_o
    );
endinterface

// File: rtl/cluster_count_scheduler_bx_phase_gen.sv
// Bunch-crossing phase tracker and delayed capture strobe for the counter pipeline.
module bx_phase_gen #(
    parameter int LATENCY = 8
) (
    input  logic       clock4x,
    input  logic       reset,
    input  logic       bx0,
    output logic [1:0] phase,
    output logic       sample,
    output logic       strobe
);
    logic [LATENCY-1:0] sample_sr;

    assign sample = (phase == 2'd0);
    assign strobe = sample_sr[LATENCY-1];

    // Phase counter; bx0 forces phase 0 on the following cycle.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) phase <= 2'd0;
        else       phase <= bx0 ? 2'd0 : phase + 2'd1;
    end

    // Delay the sample marker by the counter pipeline depth.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) sample_sr <= '0;
        else       sample_sr <= LATENCY'({sample_sr, sample});
    end
endmodule

// File: rtl/cluster_count_scheduler.sv
// Captures per-crossing cluster counts and schedules their readout slots.
module cluster_count_scheduler
    import cluster_count_scheduler_pkg::*;
#(
    parameter int LATENCY      = 8,
    parameter int MAX_CLUSTERS = MAX_CLUSTERS_DEF,
    parameter int OVF_W        = 16
) (
    input  logic                     clock4x,
    input  logic                     reset,
    cluster_count_scheduler_if.slave bus
);
    logic              strobe;
    logic              new_ovf;
    logic [SLOT_W-1:0] new_clamp;
    logic [SLOT_W-1:0] clamp_q;
    logic              last_slot;
    rd_state_t         state;

    assign new_clamp = clamp_cnt(bus.cnt_i, SLOT_W'(MAX_CLUSTERS));
    assign new_ovf   = bus.cnt_i > CNT_W'(MAX_CLUSTERS);
    assign last_slot = (bus.slot_idx_o == clamp_q - SLOT_W'(1));

    bx_phase_gen #(.LATENCY(LATENCY)) u_phase (
        .clock4x (clock4x),
        .reset   (reset),
        .bx0     (bus.bx0_i),
        .phase   (bus.phase_o),
        .sample  (bus.sample_o),
        .strobe  (strobe)
    );

    // Capture the count on the delayed strobe and hold it until the next one.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            bus.cnt_o       <= '0;
            bus.overflow_o  <= 1'b0;
            bus.cnt_valid_o <= 1'b0;
        end else begin
            bus.cnt_valid_o <= strobe;
            if (strobe) begin
                bus.cnt_o      <= bus.cnt_i;
                bus.overflow_o <= new_ovf;
            end
        end
    end

    // Sticky sync error and saturating overflow counter; clear has priority.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            bus.sync_err_o <= 1'b0;
            bus.ovf_cnt_o  <= '0;
        end else if (bus.clr_i) begin
            bus.sync_err_o <= 1'b0;
            bus.ovf_cnt_o  <= '0;
        end else begin
            if (bus.bx0_i && bus.phase_o != 2'd3) bus.sync_err_o <= 1'b1;
            if (strobe && new_ovf && !(&bus.ovf_cnt_o)) bus.ovf_cnt_o <= bus.ovf_cnt_o + 1'b1;
        end
    end

    // Readout FSM: a capture (re)starts a readout; acks walk the slot index.
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            clamp_q         <= '0;
            bus.slot_idx_o  <= '0;
            bus.slot_req_o  <= 1'b0;
            bus.truncated_o <= 1'b0;
        end else begin
            bus.truncated_o <= 1'b0;
            if (strobe) begin
                // Finishing the last slot on the capture cycle is a complete readout.
                if (state == ST_ISSUE && !(bus.slot_ack_i && last_slot))
                    bus.truncated_o <= 1'b1;
                clamp_q        <= new_clamp;
                bus.slot_idx_o <= '0;
                if (new_clamp != '0) begin
                    state          <= ST_ISSUE;
                    bus.slot_req_o <= 1'b1;
                end else begin
                    state          <= ST_IDLE;
                    bus.slot_req_o <= 1'b0;
                end
            end else if (state == ST_ISSUE && bus.slot_ack_i) begin
                if (last_slot) begin
                    state          <= ST_IDLE;
                    bus.slot_req_o <= 1'b0;
                    bus.slot_idx_o <= '0;
                end else begin
                    bus.slot_idx_o <= bus.slot_idx_o + SLOT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cluster_count_scheduler.sv
// Randomized bench for cluster_count_scheduler against a transaction-level model.
module tb_cluster_count_scheduler;
    import cluster_count_scheduler_pkg::*;

    localparam int LAT  = 8;
    localparam int MAXC = 8;
    localparam int OVFW = 3;
    localparam int OVF_MAX = (1 << OVFW) - 1;

    logic clock4x = 1'b0;
    logic reset   = 1'b1;

    cluster_count_scheduler_if #(.OVF_W(OVFW)) bus ();

    cluster_count_scheduler #(.LATENCY(LAT), .MAX_CLUSTERS(MAXC), .OVF_W(OVFW)) dut (
        .clock4x (clock4x),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clock4x = ~clock4x;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: cycle-numbered sample events and a "slots left" view of the readout.
    int cyc = 0;
    int sq[$];
    int m_phase, m_valid, m_cnt, m_ovf, m_ovfcnt, m_serr, m_trunc;
    int m_left, m_idx, m_caps;
    int trunc_dut;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit strobe_due();
        return sq.size() > 0 && sq[0] == cyc - LAT;
    endfunction

    task automatic model_reset();
        sq.delete();
        m_phase = 0; m_valid = 0; m_cnt = 0; m_ovf = 0; m_ovfcnt = 0;
        m_serr = 0; m_trunc = 0; m_left = 0; m_idx = 0;
    endtask

    task automatic check_all();
        chk("phase", bus.phase_o, m_phase);
        chk("sample", bus.sample_o, m_phase == 0);
        chk("cnt_valid", bus.cnt_valid_o, m_valid);
        chk("cnt", bus.cnt_o, m_cnt);
        chk("overflow", bus.overflow_o, m_ovf);
        chk("slot_req", bus.slot_req_o, m_left > 0);
        if (m_left > 0) chk("slot_idx", bus.slot_idx_o, m_idx);
        chk("truncated", bus.truncated_o, m_trunc);
        chk("ovf_cnt", bus.ovf_cnt_o, m_ovfcnt);
        chk("sync_err", bus.sync_err_o, m_serr);
        if (bus.truncated_o === 1'b1) trunc_dut++;
    endtask

    // Called at a falling edge: check, drive, predict the rising edge, advance.
    task automatic tick(input bit bx0, input int cnt, input bit ack, input bit clr);
        bit stb;
        int clampv;
        check_all();
        bus.bx0_i      = bx0;
        bus.cnt_i      = cnt[10:0];
        bus.slot_ack_i = ack;
        bus.clr_i      = clr;

        stb = strobe_due();
        if (stb) void'(sq.pop_front());
        if (m_phase == 0) sq.push_back(cyc);
        clampv = (cnt > MAXC) ? MAXC : cnt;

        if (clr) m_serr = 0;
        else if (bx0 && m_phase != 3) m_serr = 1;

        if (clr) m_ovfcnt = 0;
        else if (stb && cnt > MAXC && m_ovfcnt < OVF_MAX) m_ovfcnt++;

        m_trunc = 0;
        if (stb) begin
            m_caps++;
            if (m_left > 0 && !(ack && m_left == 1)) m_trunc = 1;
            m_cnt  = cnt;
            m_ovf  = cnt > MAXC;
            m_left = clampv;
            m_idx  = 0;
        end else if (m_left > 0 && ack) begin
            m_left--;
            m_idx++;
        end
        m_valid = stb;
        m_phase = bx0 ? 0 : (m_phase + 1) % 4;

        @(negedge clock4x);
        cyc++;
    endtask

    // Reset asserted asynchronously; outputs must clear without waiting for an edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_phase", bus.phase_o, 0);
        chk("rst_cnt_valid", bus.cnt_valid_o, 0);
        chk("rst_cnt", bus.cnt_o, 0);
        chk("rst_overflow", bus.overflow_o, 0);
        chk("rst_slot_req", bus.slot_req_o, 0);
        chk("rst_slot_idx", bus.slot_idx_o, 0);
        chk("rst_truncated", bus.truncated_o, 0);
        chk("rst_ovf_cnt", bus.ovf_cnt_o, 0);
        chk("rst_sync_err", bus.sync_err_o, 0);
        model_reset();
        @(negedge clock4x);
        cyc++;
        reset = 1'b0;
    endtask

    initial begin
        bit reached;
        bus.bx0_i = 1'b0; bus.cnt_i = '0; bus.slot_ack_i = 1'b0; bus.clr_i = 1'b0;
        m_caps = 0; trunc_dut = 0;
        model_reset();
        @(negedge clock4x);
        do_reset();

        // Regular crossings, count 5, always acking.
        for (int i = 0; i < 40; i++) tick(m_phase == 3, 5, 1'b1, 1'b0);

        // Overflowing counts until the narrow counter saturates.
        for (int i = 0; i < 48; i++) tick(m_phase == 3, 12, 1'b1, 1'b0);
        chk("ovf_saturated", bus.ovf_cnt_o, OVF_MAX);
        chk("overflow_flag", bus.overflow_o, 1);

        // Clear on the same cycle as an overflowing capture.
        for (int i = 0; i < 8 && !strobe_due(); i++) tick(m_phase == 3, 12, 1'b1, 1'b0);
        tick(m_phase == 3, 12, 1'b1, 1'b1);
        chk("ovf_clr_wins", bus.ovf_cnt_o, 0);

        // Stalled readout of 8 slots, then a capture of 3 truncates and restarts.
        do_reset();
        m_caps = 0; trunc_dut = 0;
        for (int i = 0; i < 40; i++) tick(m_phase == 3, (m_caps == 0) ? 8 : 3, m_caps >= 2, 1'b0);
        chk("trunc_count", trunc_dut, 1);

        // Out-of-phase crossing marker, then clear.
        for (int i = 0; i < 8 && m_phase != 1; i++) tick(m_phase == 3, 0, 1'b1, 1'b0);
        tick(1'b1, 0, 1'b1, 1'b0);
        chk("sync_err_set", bus.sync_err_o, 1);
        chk("sync_phase0", bus.phase_o, 0);
        tick(1'b0, 0, 1'b1, 1'b1);
        chk("sync_err_clr", bus.sync_err_o, 0);

        // Reset in the middle of a readout at slot 3.
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            if (m_left > 0 && m_idx == 3) reached = 1'b1;
            else tick(m_phase == 3, 8, 1'b1, 1'b0);
        end
        chk("reach_idx3", reached, 1);
        check_all();
        do_reset();

        // Random mix of crossings, counts, acks, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit bx;
            int c;
            bx = ($urandom_range(15) == 0) ? 1'b1 : (m_phase == 3);
            c  = ($urandom_range(7) == 0) ? int'($urandom_range(2047)) : int'($urandom_range(15));
            if ($urandom_range(499) == 0) do_reset();
            else tick(bx, c, $urandom_range(1) == 1, $urandom_range(63) == 0);
        end
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
